// File: rtl/data_pipe_m2s_rr_scheduler_if.sv
// Valid/ready stream carrying a DSIZE-bit payload; the source drives valid/data,
// the sink drives ready.
interface data_inf #(
   parameter int DSIZE = 8
) ();
   logic             valid;
   logic             ready;
   logic [DSIZE-1:0] data;

   modport master (output valid, output data, input ready);
   modport slaver (input valid, input data, output ready);
endinterface

// File: rtl/data_pipe_m2s_rr_scheduler.sv
// Round-robin scheduler: NUM requesters share one downstream stream in bounded
// bursts, through a main+skid output stage that tags each beat with its source.
module data_pipe_m2s_rr_scheduler #(
   parameter int DSIZE     = 8,
   parameter int NUM       = 4,
   parameter int NSIZE     = $clog2(NUM),
   parameter int BURST_MAX = 16
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             clk_en,
   data_inf.slaver          s00 [NUM-1:0],
   data_inf.master          m00,
   output logic [NSIZE-1:0] m00_path,
   output logic [NSIZE-1:0] curr_grant,
   output logic             grant_vld
);
   localparam int          CW    = $clog2(BURST_MAX + 1);
   localparam int unsigned NUM_U = NUM;

   localparam logic [0:0] ARB  = 1'b0;
   localparam logic [0:0] XFER = 1'b1;

   logic [0:0]       state;
   logic [NSIZE-1:0] rr_ptr;
   logic [NSIZE-1:0] next_ptr;
   logic [NSIZE-1:0] sel_idx;
   logic             sel_found;
   int unsigned      scan_idx;
   logic [CW-1:0]    beat_cnt;

   logic [NUM-1:0]   req_valid;
   logic [NUM-1:0]   req_ready;
   logic [DSIZE-1:0] req_data [NUM];

   logic             main_vld;
   logic [DSIZE-1:0] main_data;
   logic [NSIZE-1:0] main_path;
   logic             skid_vld;
   logic [DSIZE-1:0] skid_data;
   logic [NSIZE-1:0] skid_path;

   logic             in_xfer;
   logic             cur_valid;
   logic [DSIZE-1:0] cur_data;
   logic             accept;
   logic             pop;
   logic             last_beat;

   for (genvar i = 0; i < NUM; i++) begin : g_req
      assign req_valid[i] = s00[i].valid;
      assign req_data[i]  = s00[i].data;
      assign s00[i].ready = req_ready[i];
   end

   assign in_xfer   = (state == XFER);
   assign cur_valid = req_valid[curr_grant];
   assign cur_data  = req_data[curr_grant];
   assign pop       = main_vld & m00.ready & clk_en;
   // Ready looks only at skid occupancy, never at m00.ready.
   assign accept    = in_xfer & cur_valid & ~skid_vld & clk_en;
   assign last_beat = (beat_cnt == CW'(BURST_MAX - 1));
   assign next_ptr  = (curr_grant == NSIZE'(NUM - 1)) ? '0 : curr_grant + 1'b1;

   always_comb begin
      req_ready = '0;
      if (in_xfer && !skid_vld && clk_en) req_ready[curr_grant] = 1'b1;
   end

   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      scan_idx  = 0;
      for (int unsigned k = 0; k < NUM_U; k++) begin
         scan_idx = 32'(rr_ptr) + k;
         if (scan_idx >= NUM_U) scan_idx = scan_idx - NUM_U;
         if (!sel_found && req_valid[NSIZE'(scan_idx)]) begin
            sel_found = 1'b1;
            sel_idx   = NSIZE'(scan_idx);
         end
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state      <= ARB;
         rr_ptr     <= '0;
         beat_cnt   <= '0;
         curr_grant <= '0;
      end else if (clk_en) begin
         if (state == ARB) begin
            if (sel_found) begin
               state      <= XFER;
               curr_grant <= sel_idx;
               beat_cnt   <= '0;
            end
         end else if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (last_beat) begin
               state  <= ARB;
               rr_ptr <= next_ptr;
            end
         end else if (!cur_valid) begin
            state  <= ARB;
            rr_ptr <= next_ptr;
         end
      end
   end

   // Accept implies an empty skid, so skid->main and new->skid never collide.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         main_vld  <= 1'b0;
         main_data <= '0;
         main_path <= '0;
         skid_vld  <= 1'b0;
         skid_data <= '0;
         skid_path <= '0;
      end else begin
         if (pop) begin
            if (skid_vld) begin
               main_data <= skid_data;
               main_path <= skid_path;
               skid_vld  <= 1'b0;
            end else begin
               main_vld <= 1'b0;
            end
         end
         if (accept) begin
            if (!main_vld || pop) begin
               main_vld  <= 1'b1;
               main_data <= cur_data;
               main_path <= curr_grant;
            end else begin
               skid_vld  <= 1'b1;
               skid_data <= cur_data;
               skid_path <= curr_grant;
            end
         end
      end
   end

   assign m00.valid = main_vld;
   assign m00.data  = main_data;
   assign m00_path  = main_path;
   assign grant_vld = in_xfer;
endmodule

// File: tb/tb_data_pipe_m2s_rr_scheduler.sv
// Bench for data_pipe_m2s_rr_scheduler: two instances (BURST_MAX 16 and 4) checked
// every cycle against a queue-based scheduler model, plus directed literal checks.
module tb_data_pipe_m2s_rr_scheduler;
   localparam int NUM   = 4;
   localparam int DSIZE = 8;
   localparam int NU    = 2;

   logic             clock = 1'b0;
   logic             rst;
   logic             clk_en;
   logic             sv   [NU][NUM];
   logic [DSIZE-1:0] sd   [NU][NUM];
   logic             srdy [NU][NUM];
   logic             mrdy [NU];
   logic             mv   [NU];
   logic [DSIZE-1:0] md   [NU];
   logic [1:0]       mp   [NU];
   logic [1:0]       cg   [NU];
   logic             gv   [NU];

   always #5 clock = ~clock;

   for (genvar u = 0; u < NU; u++) begin : g_u
      data_inf #(.DSIZE(DSIZE)) s_if [NUM-1:0] ();
      data_inf #(.DSIZE(DSIZE)) m_if ();
      for (genvar i = 0; i < NUM; i++) begin : g_i
         assign s_if[i].valid = sv[u][i];
         assign s_if[i].data  = sd[u][i];
         assign srdy[u][i]    = s_if[i].ready;
      end
      assign m_if.ready = mrdy[u];
      assign mv[u]      = m_if.valid;
      assign md[u]      = m_if.data;

      data_pipe_m2s_rr_scheduler #(
         .DSIZE     (DSIZE),
         .NUM       (NUM),
         .BURST_MAX ((u == 0) ? 16 : 4)
      ) dut (
         .clock      (clock),
         .rst        (rst),
         .clk_en     (clk_en),
         .s00        (s_if),
         .m00        (m_if),
         .m00_path   (mp[u]),
         .curr_grant (cg[u]),
         .grant_vld  (gv[u])
      );
   end

   typedef struct {
      int cyc;
      int path;
      int data;
   } pop_t;

   int         checks = 0;
   int         errors = 0;
   int         cyc    = 0;
   logic [7:0] src_q [NU][NUM][$];
   pop_t       plog  [NU][$];

   // Model: grant state, pointer, burst count, and the buffered beats as a queue.
   bit         m_x   [NU];
   int         m_g   [NU];
   int         m_ptr [NU];
   int         m_cnt [NU];
   int         m_q   [NU][$];

   function automatic int bmax(input int u);
      return (u == 0) ? 16 : 4;
   endfunction

   task automatic chk_eq(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      int sz;
      bit pop;
      bit acc;
      int hit;
      int j;
      cyc++;
      for (int u = 0; u < NU; u++) begin
         if (rst) begin
            m_x[u]   = 1'b0;
            m_g[u]   = 0;
            m_ptr[u] = 0;
            m_cnt[u] = 0;
            m_q[u].delete();
            chk_eq("rst_m00_valid", int'(mv[u]), 0);
            chk_eq("rst_m00_data", int'(md[u]), 0);
            chk_eq("rst_m00_path", int'(mp[u]), 0);
            chk_eq("rst_curr_grant", int'(cg[u]), 0);
            chk_eq("rst_grant_vld", int'(gv[u]), 0);
            for (int i = 0; i < NUM; i++) chk_eq("rst_ready", int'(srdy[u][i]), 0);
         end else begin
            sz = m_q[u].size();
            chk_eq("grant_vld", int'(gv[u]), int'(m_x[u]));
            if (m_x[u]) chk_eq("curr_grant", int'(cg[u]), m_g[u]);
            chk_eq("m00_valid", int'(mv[u]), int'(sz > 0));
            if (sz > 0) begin
               chk_eq("m00_data", int'(md[u]), m_q[u][0] % 256);
               chk_eq("m00_path", int'(mp[u]), m_q[u][0] / 256);
            end
            for (int i = 0; i < NUM; i++)
               chk_eq("s00_ready", int'(srdy[u][i]),
                      int'(clk_en && m_x[u] && m_g[u] == i && sz < 2));

            if (mv[u] && mrdy[u] && clk_en)
               plog[u].push_back('{cyc, int'(mp[u]), int'(md[u])});

            if (clk_en) begin
               pop = (sz > 0) && mrdy[u];
               acc = m_x[u] && sv[u][m_g[u]] && (sz < 2);
               if (pop) void'(m_q[u].pop_front());
               if (acc) m_q[u].push_back(m_g[u] * 256 + int'(sd[u][m_g[u]]));
               if (!m_x[u]) begin
                  hit = -1;
                  for (int k = 0; k < NUM; k++) begin
                     j = (m_ptr[u] + k) % NUM;
                     if (hit < 0 && sv[u][j]) hit = j;
                  end
                  if (hit >= 0) begin
                     m_x[u]   = 1'b1;
                     m_g[u]   = hit;
                     m_cnt[u] = 0;
                  end
               end else if (acc) begin
                  m_cnt[u]++;
                  if (m_cnt[u] == bmax(u)) begin
                     m_x[u]   = 1'b0;
                     m_ptr[u] = (m_g[u] + 1) % NUM;
                  end
               end else if (!sv[u][m_g[u]]) begin
                  m_x[u]   = 1'b0;
                  m_ptr[u] = (m_g[u] + 1) % NUM;
               end
            end
         end
      end
   end

   task automatic drive();
      for (int u = 0; u < NU; u++)
         for (int i = 0; i < NUM; i++) begin
            sv[u][i] = (src_q[u][i].size() > 0);
            sd[u][i] = '0;
            if (src_q[u][i].size() > 0) sd[u][i] = src_q[u][i][0];
         end
   endtask

   // One clock: note which sources will transfer, take the edge, advance them.
   task automatic step();
      bit tk [NU][NUM];
      @(negedge clock);
      #1;
      for (int u = 0; u < NU; u++)
         for (int i = 0; i < NUM; i++)
            tk[u][i] = sv[u][i] && srdy[u][i] && clk_en && !rst;
      @(posedge clock);
      #1;
      for (int u = 0; u < NU; u++)
         for (int i = 0; i < NUM; i++)
            if (tk[u][i]) void'(src_q[u][i].pop_front());
      drive();
   endtask

   task automatic wait_pops(input int u, input int n, input int budget);
      int t;
      t = 0;
      while (plog[u].size() < n && t < budget) begin
         step();
         t++;
      end
      if (plog[u].size() < n) chk_eq("pop_timeout", plog[u].size(), n);
   endtask

   task automatic chk_pop(input string name, input int u, input int idx,
                          input int path, input int data);
      if (idx >= plog[u].size()) begin
         chk_eq({name, "_missing"}, plog[u].size(), idx + 1);
      end else begin
         chk_eq({name, "_path"}, plog[u][idx].path, path);
         chk_eq({name, "_data"}, plog[u][idx].data, data);
      end
   endtask

   task automatic chk_gap(input string name, input int u, input int idx, input int gap);
      if (idx >= plog[u].size()) chk_eq({name, "_missing"}, plog[u].size(), idx + 1);
      else chk_eq(name, plog[u][idx].cyc - plog[u][idx-1].cyc, gap);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      int base;
      rst    = 1'b1;
      clk_en = 1'b1;
      for (int u = 0; u < NU; u++) mrdy[u] = 1'b0;
      drive();
      repeat (3) step();
      chk_eq("init_m00_valid", int'(mv[0]), 0);
      chk_eq("init_grant_vld", int'(gv[1]), 0);
      rst = 1'b0;
      mrdy[0] = 1'b1;
      mrdy[1] = 1'b1;

      // Single requester, 20 beats, burst 16.
      base = plog[0].size();
      for (int k = 1; k <= 20; k++) src_q[0][2].push_back(8'(k));
      drive();
      wait_pops(0, base + 20, 100);
      for (int k = 0; k < 20; k++) chk_pop("single", 0, base + k, 2, k + 1);
      for (int k = 1; k < 20; k++) chk_gap("single_gap", 0, base + k, (k == 16) ? 2 : 1);
      repeat (4) step();

      // Four requesters continuously valid, burst 4.
      base = plog[1].size();
      for (int i = 0; i < NUM; i++)
         for (int k = 0; k < 12; k++) src_q[1][i].push_back(8'(i * 16 + k));
      drive();
      wait_pops(1, base + 48, 200);
      for (int n = 0; n < 48; n++)
         chk_pop("rr", 1, base + n, (n / 4) % 4, ((n / 4) % 4) * 16 + (n / 16) * 4 + n % 4);
      for (int n = 1; n < 48; n++) chk_gap("rr_gap", 1, base + n, (n % 4 == 0) ? 2 : 1);
      repeat (4) step();

      // Downstream stall mid-burst.
      base = plog[0].size();
      for (int k = 0; k < 8; k++) src_q[0][0].push_back(8'(8'h30 + k));
      drive();
      wait_pops(0, base + 3, 20);
      mrdy[0] = 1'b0;
      repeat (2) step();
      chk_eq("stall_ready_low", int'(srdy[0][0]), 0);
      chk_eq("stall_m00_valid", int'(mv[0]), 1);
      repeat (3) step();
      chk_eq("stall_no_pop", plog[0].size(), base + 3);
      mrdy[0] = 1'b1;
      wait_pops(0, base + 8, 40);
      for (int k = 0; k < 8; k++) chk_pop("stall", 0, base + k, 0, 8'h30 + k);
      repeat (4) step();

      // Idle release from requester 1 while requester 3 waits.
      base = plog[0].size();
      for (int k = 0; k < 3; k++) begin
         src_q[0][1].push_back(8'(8'h41 + k));
         src_q[0][3].push_back(8'(8'h61 + k));
      end
      drive();
      wait_pops(0, base + 6, 40);
      for (int k = 0; k < 3; k++) chk_pop("idle_rel_1", 0, base + k, 1, 8'h41 + k);
      for (int k = 0; k < 3; k++) chk_pop("idle_rel_3", 0, base + 3 + k, 3, 8'h61 + k);
      repeat (4) step();

      // clk_en held low for 3 cycles with traffic on both sides.
      base = plog[1].size();
      for (int k = 0; k < 6; k++) src_q[1][2].push_back(8'(8'h71 + k));
      drive();
      repeat (3) step();
      chk_eq("gate_pre_pops", plog[1].size(), base + 1);
      clk_en = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         chk_eq("gate_m00_valid", int'(mv[1]), 1);
         chk_eq("gate_m00_data", int'(md[1]), 8'h72);
         chk_eq("gate_m00_path", int'(mp[1]), 2);
         chk_eq("gate_grant", int'(cg[1]), 2);
         chk_eq("gate_grant_vld", int'(gv[1]), 1);
         chk_eq("gate_ready", int'(srdy[1][2]), 0);
      end
      chk_eq("gate_no_pop", plog[1].size(), base + 1);
      clk_en = 1'b1;
      wait_pops(1, base + 6, 40);
      for (int k = 0; k < 6; k++) chk_pop("gate", 1, base + k, 2, 8'h71 + k);
      chk_gap("gate_gap_hold", 1, base + 1, 4);
      chk_gap("gate_gap_burst", 1, base + 4, 2);
      repeat (4) step();

      // Async reset with the skid full.
      mrdy[0] = 1'b0;
      for (int k = 0; k < 10; k++) src_q[0][1].push_back(8'(8'h81 + k));
      for (int k = 0; k < 4; k++) src_q[0][3].push_back(8'(8'h91 + k));
      drive();
      repeat (3) step();
      chk_eq("skid_full_ready", int'(srdy[0][1]), 0);
      chk_eq("skid_full_valid", int'(mv[0]), 1);
      #1 rst = 1'b1;
      #1;
      chk_eq("async_rst_valid", int'(mv[0]), 0);
      chk_eq("async_rst_grant_vld", int'(gv[0]), 0);
      for (int i = 0; i < NUM; i++) chk_eq("async_rst_ready", int'(srdy[0][i]), 0);
      repeat (2) step();
      rst = 1'b0;
      mrdy[0] = 1'b1;
      base = plog[0].size();
      wait_pops(0, base + 12, 60);
      for (int k = 0; k < 8; k++) chk_pop("post_rst_1", 0, base + k, 1, 8'h83 + k);
      for (int k = 0; k < 4; k++) chk_pop("post_rst_3", 0, base + 8 + k, 3, 8'h91 + k);
      repeat (4) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
